// File: rtl/reorder_buffer.sv
`default_nettype none
// ==========================================================================
// reorder_buffer : in-order retirement buffer, one alloc / one commit per cycle
// Revision: 1.0
// ==========================================================================
module reorder_buffer #(
  parameter int ROB_DEPTH  = 16,
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic                            alloc_has_dest,
  input  logic [$clog2(NUM_A_REGS)-1:0]   alloc_areg,
  input  logic [$clog2(NUM_P_REGS)-1:0]   alloc_preg,
  input  logic [$clog2(NUM_P_REGS)-1:0]   alloc_old_preg,
  output logic [$clog2(ROB_DEPTH)-1:0]    alloc_tag,
  input  logic                            wb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0]    wb_tag,
  input  logic                            wb_exception,
  output logic                            commit_valid,
  output logic                            commit_has_dest,
  output logic [$clog2(NUM_A_REGS)-1:0]   commit_areg,
  output logic [$clog2(NUM_P_REGS)-1:0]   commit_preg,
  output logic                            free_valid,
  output logic [$clog2(NUM_P_REGS)-1:0]   free_preg,
  output logic                            flush,
  output logic [$clog2(ROB_DEPTH):0]      count
);

  localparam int IDX_W  = $clog2(ROB_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int AREG_W = $clog2(NUM_A_REGS);
  localparam int PREG_W = $clog2(NUM_P_REGS);

  logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d;
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 has_dest_q [ROB_DEPTH];
  logic                 has_dest_d [ROB_DEPTH];
  logic [AREG_W-1:0]    areg_q     [ROB_DEPTH];
  logic [AREG_W-1:0]    areg_d     [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_q     [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_d     [ROB_DEPTH];
  logic [PREG_W-1:0]    old_preg_q [ROB_DEPTH];
  logic [PREG_W-1:0]    old_preg_d [ROB_DEPTH];

  logic head_ready;
  logic alloc_fire;

  // Retire-side outputs are masked while reset is held so nothing leaks out.
  assign head_ready      = valid_q[head_q] & done_q[head_q];
  assign commit_valid    = rst_n & head_ready & ~exc_q[head_q];
  assign flush           = rst_n & head_ready &  exc_q[head_q];
  assign alloc_ready     = ~rst_n | ((count_q < CNT_W'(ROB_DEPTH)) & ~flush);
  assign alloc_fire      = alloc_valid & alloc_ready;
  assign alloc_tag       = tail_q;
  assign count           = count_q;
  assign commit_has_dest = has_dest_q[head_q];
  assign commit_areg     = areg_q[head_q];
  assign commit_preg     = preg_q[head_q];
  assign free_valid      = commit_valid & has_dest_q[head_q];
  assign free_preg       = old_preg_q[head_q];

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    exc_d      = exc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    has_dest_d = has_dest_q;
    areg_d     = areg_q;
    preg_d     = preg_q;
    old_preg_d = old_preg_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_valid && valid_q[wb_tag]) begin
        done_d[wb_tag] = 1'b1;
        exc_d[wb_tag]  = wb_exception;
      end
      if (commit_valid) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      // The tail slot is never the head being written back unless full, so no overlap.
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        done_d[tail_q]     = 1'b0;
        exc_d[tail_q]      = 1'b0;
        has_dest_d[tail_q] = alloc_has_dest;
        areg_d[tail_q]     = alloc_areg;
        preg_d[tail_q]     = alloc_preg;
        old_preg_d[tail_q] = alloc_old_preg;
        tail_d             = tail_q + 1'b1;
      end
      case ({alloc_fire, commit_valid})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    has_dest_q <= has_dest_d;
    areg_q     <= areg_d;
    preg_q     <= preg_d;
    old_preg_q <= old_preg_d;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16, sets the number of in-flight entries and SHALL be a power of two.
REQ-002 Parameter NUM_A_REGS, default 32, sets the architectural register count; the areg width is log2 of this value (5).
REQ-003 Parameter NUM_P_REGS, default 64, sets the physical register count; the preg width is log2 of this value (6).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 alloc_valid  input  1  rename stage presents a renamed instruction.
REQ-007 alloc_ready  output  1  ROB can accept an allocation this cycle.
REQ-008 alloc_has_dest  input  1  instruction writes a destination register.
REQ-009 alloc_areg  input  5  architectural destination register.
REQ-010 alloc_preg  input  6  newly mapped physical destination register.
REQ-011 alloc_old_preg  input  6  previous RAT mapping of alloc_areg.
REQ-012 alloc_tag  output  4  ROB index that an accepted allocation receives (current tail).
REQ-013 wb_valid  input  1  execution completion strobe.
REQ-014 wb_tag  input  4  ROB index of the completing instruction.
REQ-015 wb_exception  input  1  completing instruction raised an exception.
REQ-016 commit_valid  output  1  the head entry retires this cycle.
REQ-017 commit_has_dest, commit_areg, commit_preg  output  1/5/6  retiring entry's fields, used for the architectural RAT update.
REQ-018 free_valid  output  1  return a physical register to the rename free list.
REQ-019 free_preg  output  6  physical register being freed (the retiring entry's old_preg).
REQ-020 flush  output  1  exception at head; the pipeline must squash.
REQ-021 count  output  5  number of occupied entries, 0..16.

Function
REQ-022 Storage SHALL be a circular buffer of ROB_DEPTH entries, each holding {valid, done, exc, has_dest, areg, preg, old_preg}, with 4-bit head and tail pointers that wrap naturally from 15 to 0.
REQ-023 alloc_ready SHALL equal (count < ROB_DEPTH) AND NOT flush; a same-cycle commit SHALL NOT bypass a full condition.
REQ-024 When alloc_valid AND alloc_ready, the entry at tail SHALL be written with valid=1, done=0, exc=0 and the input fields, and tail SHALL increment on that edge.
REQ-025 alloc_tag SHALL equal tail combinationally.
REQ-026 When wb_valid is high and entry[wb_tag].valid is 1, the entry SHALL set done=1 and exc=wb_exception on that edge.
REQ-027 A wb_valid to an invalid entry SHALL be ignored with no state change.
REQ-028 commit_valid SHALL be driven combinationally as entry[head].valid AND done AND NOT exc, so a writeback in cycle N commits in cycle N+1 at the earliest.
REQ-029 On commit, head SHALL increment and entry[head].valid SHALL clear; the ROB retires at most one entry per cycle and commit has no backpressure.
REQ-030 commit_* outputs SHALL reflect entry[head] whenever commit_valid=1.
REQ-031 free_valid SHALL equal commit_valid AND entry[head].has_dest, with free_preg = entry[head].old_preg.
REQ-032 flush SHALL be driven combinationally as entry[head].valid AND done AND exc.
REQ-033 In a flush cycle, commit_valid=0, free_valid=0, and any allocation or writeback that cycle SHALL be discarded.
REQ-034 After a flush cycle, all valid bits, head, tail and count SHALL be 0 on the next edge.
REQ-035 count SHALL be updated as +1 on allocate, -1 on commit, and unchanged when both occur; it is held as a register consistent with head and tail.
REQ-036 The buffer SHALL be empty when count=0 and full when count=16; head equal to tail alone SHALL NOT be used to decide empty versus full.
REQ-037 A writeback to the head entry in the same cycle as an allocation while count=15 SHALL be legal, with both taking effect.

Reset
REQ-038 While rst_n=0 at a clock edge, head, tail and count SHALL be set to 0 and all valid, done and exc bits cleared.
REQ-039 Reset SHALL take priority over any simultaneous allocate, writeback or commit.
REQ-040 During and after reset, alloc_ready=1 and commit_valid, free_valid and flush = 0.
REQ-041 The payload fields (areg, preg, old_preg) need not be reset.
REQ-042 Asserting reset mid-operation SHALL discard all in-flight entries without emitting any commit or free.

Verification
REQ-043 Reset, then allocate 16 entries back-to-back -> alloc_tag runs 0..15, count=16 and alloc_ready=0 on the 17th cycle.
REQ-044 Write back tags 2, 0, 1 in that order -> no commit until tag 0 is done; tags 0, 1 and 2 then commit in consecutive cycles in order, and free_preg equals each entry's old_preg.
REQ-045 Entry with has_dest=0 commits -> commit_valid=1 with free_valid=0.
REQ-046 Head writeback with wb_exception=1 while count=5 -> flush=1 for one cycle with no commit; next cycle count=0, head=tail=0, alloc_ready=1.
REQ-047 Cycle allocate and commit continuously across 40 instructions -> tail and head wrap 15->0 and commit order is preserved; with count=16, a simultaneous commit still leaves alloc_ready=0 that cycle.
REQ-048 Assert rst_n=0 for one cycle with 8 entries in flight -> next cycle count=0 and no commit_valid or free_valid pulses occur.
